// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the two requester channels, the two response channels and the
// shared-ALU connection of alu_arbiter.
//   req0_*/req1_* : request valid/ready handshake with operands and op code
//   rsp0_*/rsp1_* : response valid/ready handshake; rsp_y is shared
//   alu_a/alu_b/alu_control/alu_y : to/from the combinational alu instance
//   busy          : arbiter is not idle
// Modports: slave = the arbiter, master = clients plus the alu.
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int DW = 32
);
    logic          req0_valid;
    logic          req0_ready;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic [1:0]    req0_op;

    logic          req1_valid;
    logic          req1_ready;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic [1:0]    req1_op;

    logic          rsp0_valid;
    logic          rsp0_ready;
    logic          rsp1_valid;
    logic          rsp1_ready;
    logic [DW-1:0] rsp_y;

    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [1:0]    alu_control;
    logic [DW-1:0] alu_y;

    logic          busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready, alu_y,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_y,
        output alu_a, alu_b, alu_control, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready, alu_y,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_y,
        input  alu_a, alu_b, alu_control, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Round-robin arbiter and sequencer that shares one combinational alu
// between two requesters. One operation at a time: IDLE accepts a request
// and registers its operands onto the alu, EXEC captures alu_y into rsp_y,
// RESP presents the result to the granted requester until it is consumed.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_arbiter_if.slave (request, response and alu signals)
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DW = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_RESP = 2'b10;

    logic [1:0]    state;
    logic          last;   // most recently served requester
    logic          gnt;    // requester owning the operation in flight

    logic          any_req;
    logic          grant;
    logic [DW-1:0] sel_a;
    logic [DW-1:0] sel_b;
    logic [1:0]    sel_op;
    logic          rsp_fire;

    // Grant: a lone requester wins; on contention the one not served last.
    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch is inferred.
        any_req = bus.req0_valid | bus.req1_valid;
        grant   = (bus.req0_valid && bus.req1_valid) ? ~last : bus.req1_valid;
        sel_a   = grant ? bus.req1_a  : bus.req0_a;
        sel_b   = grant ? bus.req1_b  : bus.req0_b;
        sel_op  = grant ? bus.req1_op : bus.req0_op;
    end

    // rst_n is folded in so no request is acknowledged while reset is held.
    assign bus.req0_ready = rst_n && (state == S_IDLE) && any_req && !grant;
    assign bus.req1_ready = rst_n && (state == S_IDLE) && any_req &&  grant;

    assign bus.rsp0_valid = (state == S_RESP) && !gnt;
    assign bus.rsp1_valid = (state == S_RESP) &&  gnt;
    assign rsp_fire       = (state == S_RESP) && (gnt ? bus.rsp1_ready : bus.rsp0_ready);

    assign bus.busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state           <= S_IDLE;
            last            <= 1'b1;
            gnt             <= 1'b0;
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.alu_control <= 2'b00;
            bus.rsp_y       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Any valid request is the granted one's handshake.
                    if (any_req) begin
                        bus.alu_a       <= sel_a;
                        bus.alu_b       <= sel_b;
                        bus.alu_control <= sel_op;
                        gnt             <= grant;
                        state           <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    bus.rsp_y <= bus.alu_y;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_fire) begin
                        last  <= gnt;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared single-adder `alu`. Each requester submits an operand pair and a 2-bit `alu_control` code over a valid/ready handshake. The block grants one request at a time and drives the registered operands onto the combinational ALU. It captures `y` into a result register and returns the result to the granted requester over a separate valid/ready response channel. It sits between the instruction/issue logic of the clients and the `alu` instance, which is the only ALU in the datapath.

## Interface
- `DW`, default 32: operand/result width; must equal the `DW` of the attached `alu`.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid`, `req1_valid` in 1: request pending from requester 0 / 1.
- `req0_ready`, `req1_ready` out 1: request accepted this cycle (combinational from state and grant).
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in DW: operands.
- `req0_op`, `req1_op` in 2: `alu_control` code, passed through unmodified.
- `rsp0_valid`, `rsp1_valid` out 1: result available for requester 0 / 1.
- `rsp0_ready`, `rsp1_ready` in 1: requester consumes result.
- `rsp_y` out DW: result register, shared by both response channels.
- `alu_a`, `alu_b` out DW: to `alu.A` / `alu.B`.
- `alu_control` out 2: to `alu.alu_control`.
- `alu_y` in DW: from `alu.y`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Encoding is free.
- The `last` pointer (1 bit) records the most recently served requester. Its reset value is 1, so requester 0 wins the first contention.
- Grant in IDLE:
  - Only one valid: that requester.
  - Both valid: the requester != `last`.
  - None valid: no grant.
- IDLE:
  - Assert the granted requester's `reqN_ready`. The other ready stays 0.
  - On handshake, register `a`, `b`, `op` into `alu_a`, `alu_b`, `alu_control`, store the grant index in `gnt`, and go to EXEC.
- EXEC (exactly 1 cycle):
  - The ALU inputs are stable from registers.
  - At the end of the cycle, `rsp_y <= alu_y`, then go to RESP.
- RESP:
  - Assert `rsp<gnt>_valid`. The other `rsp_valid` is 0.
  - Hold `rsp_y` and the valid until `rsp<gnt>_ready`.
  - On the response handshake: `last <= gnt`, go to IDLE.
- Requests are not accepted in EXEC or RESP. Both ready outputs are 0 there; `reqN_valid` may stay high and is served later.
- `alu_a`, `alu_b` and `alu_control` hold their last value outside EXEC. They are not cleared.
- Operand and result widths are exactly DW; no width conversion. Overflow and wrap-around are the ALU's behaviour; the arbiter is transparent.
- Requester inputs are sampled only at the request handshake. Changes after acceptance do not affect the operation in flight.

## Timing
- Reset values (asserted asynchronously, released synchronously to `clk`):
  - State IDLE, `last` = 1, `gnt` = 0.
  - `alu_a`, `alu_b`, `rsp_y` = 0; `alu_control` = 2'b00.
  - All `rsp_valid` = 0, `busy` = 0.
  - `req_ready` = 0 while in reset.
- Latency: request handshake at edge N, so `alu_*` are updated after N. `rsp_y` is captured at N+1, and `rspN_valid` is high from N+1 to the response handshake.
- Next request acceptance: earliest the cycle after the response handshake, in IDLE. Maximum throughput is one op per 3 cycles with `rsp_ready` held high.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,… Neither requester waits more than one other operation.
- Reset mid-operation (EXEC or RESP): the in-flight op is dropped and no response is produced. All outputs go to their reset values immediately; `last` returns to 1.
- Back-pressure: `rsp_ready` low holds RESP indefinitely. `rsp_y` and `rsp_valid` must not change while waiting.

## Test plan
- Single request: `req0` a=10, b=20, op=2'b00, with a bench ALU model returning a+b. Required:
  - `req0_ready` in the first IDLE cycle.
  - `alu_a`=10, `alu_b`=20, `alu_control`=0 the next cycle.
  - `rsp0_valid` with `rsp_y`=30 two edges after acceptance.
  - `rsp1_valid` stays 0.
- Contention from reset: `req0` (0,5,op 2'b11) and `req1` (10,20,op 2'b01) valid together, `rsp_ready` high. Required:
  - `req0` served first (`rsp0_valid`), then `req1`.
  - `alu_control` = 3 then 1.
  - Both operations complete within 6 cycles.
- Sustained contention: both valid for 8 operations. Required:
  - Grant order 0,1,0,1,0,1,0,1.
  - `busy` low exactly one cycle between operations.
- Back-pressure: `rsp0_ready` held low for 5 cycles after `rsp0_valid` rises, with the result 7. Required:
  - `rsp_y`=7 and `rsp0_valid` stable throughout.
  - `req1_ready` stays 0 even though `req1_valid`=1.
  - `req1` is accepted the cycle after `rsp0_ready` rises.
- Operand change after accept: change `req0_a` from 10 to 99 one cycle after the handshake. Required: `alu_a` stays 10 and `rsp_y` reflects 10.
- Reset in EXEC: `rst_n`=0 asserted in the EXEC cycle. Required:
  - `busy`, `rsp_valid` and `alu_*` go to 0 without a clock edge.
  - No response is delivered after release.
  - Next contention grants requester 0.
